l2_lookup_pipe: RTL and testbench
=================================

# l2_lookup_pipe

Parametrised, handshaked tag-lookup stage for the Spandex L2 pipeline. It compares an incoming tag against the tag/state buffers of one set and returns the hit way, the first empty way and a victim way. Victims come from a round-robin pointer when the set is full. It sits between the tag/state RAM read stage and the L2 request/forward handlers. It replaces the fixed-width lookup with one registered, back-pressurable stage that adds victim selection, multi-hit detection and an eviction-probe mode.

## Interface
Parameters:
- WAYS, 8: associativity; power of two, >= 2
- TAG_BITS, 20: tag width
- STATE_BITS, 3: coherence state width
- INVALID_STATE, 0: state encoding treated as an empty way
- WAY_BITS, $clog2(WAYS): derived way-index width; not overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  lookup request valid
- in_ready  out  1  stage can accept a request this cycle
- in_mode  in  2  0 = LOOKUP, 1 = LOOKUP_FWD, 2 = LOOKUP_EVICT, 3 = reserved (treated as LOOKUP_FWD)
- in_tag  in  TAG_BITS  tag to match
- in_tags  in  WAYS*TAG_BITS  set tags, way i at bits [i*TAG_BITS +: TAG_BITS]
- in_states  in  WAYS*STATE_BITS  set states, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_mode  out  2  mode of the returned result
- out_tag_hit  out  1  tag matched a non-invalid way
- out_way_hit  out  WAY_BITS  lowest-index matching way
- out_empty_found  out  1  some way is INVALID_STATE (LOOKUP/EVICT only)
- out_empty_way  out  WAY_BITS  lowest-index empty way
- out_evict_way  out  WAY_BITS  victim way (LOOKUP/EVICT only)
- out_multi_hit  out  1  more than one valid way matched (protocol error)

## Operation
- Accept: transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, so a full-throughput bubble-free pipe is possible.
- Combinational compare on the request fields; all results are captured into the output register on accept.
- Hit: way i matches when in_tags[i] == in_tag and in_states[i] != INVALID_STATE. Lowest index wins. tag_hit = OR of matches. multi_hit = popcount(matches) > 1.
- Empty: way i is empty when in_states[i] == INVALID_STATE. Lowest index wins.
- LOOKUP: hit, empty and evict outputs are all computed.
- LOOKUP_FWD (and mode 3): only hit and multi_hit are computed. empty_found = 0, empty_way = 0, evict_way = 0.
- LOOKUP_EVICT: as LOOKUP, but tag_hit, way_hit and multi_hit are forced to 0.
- Victim selection:
  - If empty_found, evict_way = empty_way.
  - Otherwise evict_way = rr_ptr.
- rr_ptr (WAY_BITS) advances by 1, modulo WAYS (WAYS-1 wraps to 0), on every accepted request that meets all of:
  - mode is LOOKUP or EVICT;
  - no empty way;
  - for LOOKUP, additionally no tag_hit.
- Output register: holds its values while out_valid && !out_ready. It is overwritten when a new request is accepted in the same cycle out_ready is high. out_valid falls when out_ready is high and no request is accepted.
- in_* fields are don't-care when in_valid = 0. They must stay stable only during the cycle of the transfer.

## Timing
- Latency: 1 cycle, accept at edge N, out_valid high after edge N.
- Throughput: 1 result per cycle while out_ready is held high.
- Reset (asynchronous, immediate): out_valid = 0, all result outputs = 0, out_mode = 0, rr_ptr = 0. in_ready = 1 once rst deasserts.
- Reset mid-operation: a pending result is discarded with no replay. rr_ptr restarts at 0.
- Simultaneous out_ready and in_valid while out_valid = 1: old result is consumed and new result loaded at the same edge. No bubble.
- Back-pressure: out_valid = 1 and out_ready = 0 forces in_ready = 0. No request is lost and rr_ptr does not move.
- All tags equal and valid: multi_hit = 1, way_hit = 0.

## Test plan
- Reset, then LOOKUP with WAYS = 8, tag 0x123 in way 5 (valid), way 2 invalid -> next cycle: out_valid = 1, tag_hit = 1, way_hit = 5, empty_found = 1, empty_way = 2, evict_way = 2, rr_ptr stays 0.
- Eight back-to-back LOOKUP misses on a full set with out_ready = 1 -> evict_way sequence 0,1,…,7, then 0 on the ninth (wrap). One result per cycle.
- LOOKUP_FWD, tag in way 3, way 0 invalid -> tag_hit = 1, way_hit = 3, empty_found = 0, evict_way = 0. rr_ptr unchanged.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable. On release, first result consumed and next loaded on the same edge.
- Tag valid in ways 1 and 6 -> multi_hit = 1, way_hit = 1. LOOKUP_EVICT on the same set -> tag_hit = 0, multi_hit = 0, evict_way = rr_ptr.
- Assert rst while out_valid = 1 and rr_ptr = 4 -> out_valid = 0 immediately (before next edge). After release, a full-set miss gives evict_way = 0.

Source files
------------

// File: rtl/l2_lookup_pipe_if.sv
// l2_lookup_pipe_if: request/result handshake bundle for the L2 tag-lookup stage
//   master: drives in_valid/in_mode/in_tag/in_tags/in_states and out_ready
//   slave : drives in_ready and all out_* result fields
interface l2_lookup_pipe_if #(
    parameter int WAYS = 8,
    parameter int TAG_BITS = 20,
    parameter int STATE_BITS = 3,
    parameter int WAY_BITS = $clog2(WAYS)
);
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 in_mode;
    logic [TAG_BITS-1:0]        in_tag;
    logic [WAYS*TAG_BITS-1:0]   in_tags;
    logic [WAYS*STATE_BITS-1:0] in_states;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_mode;
    logic                       out_tag_hit;
    logic [WAY_BITS-1:0]        out_way_hit;
    logic                       out_empty_found;
    logic [WAY_BITS-1:0]        out_empty_way;
    logic [WAY_BITS-1:0]        out_evict_way;
    logic                       out_multi_hit;

    modport master (
        output in_valid, in_mode, in_tag, in_tags, in_states, out_ready,
        input  in_ready, out_valid, out_mode, out_tag_hit, out_way_hit,
               out_empty_found, out_empty_way, out_evict_way, out_multi_hit
    );

    modport slave (
        input  in_valid, in_mode, in_tag, in_tags, in_states, out_ready,
        output in_ready, out_valid, out_mode, out_tag_hit, out_way_hit,
               out_empty_found, out_empty_way, out_evict_way, out_multi_hit
    );
endinterface

// File: rtl/l2_lookup_pipe.sv
// l2_lookup_pipe: registered tag lookup of one set with hit/empty/victim selection
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of l2_lookup_pipe_if (request in, registered result out)
module l2_lookup_pipe #(
    parameter int WAYS = 8,
    parameter int TAG_BITS = 20,
    parameter int STATE_BITS = 3,
    parameter int INVALID_STATE = 0,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input logic               clk,
    input logic               rst,
    l2_lookup_pipe_if.slave   bus
);
    logic [WAYS-1:0]     match;
    logic [WAYS-1:0]     empty;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] empty_way;
    logic [WAY_BITS-1:0] rr_ptr;
    logic                is_fwd;
    logic                is_evict;
    logic                any_empty;
    logic                any_hit;
    logic                multi;
    logic                accept;
    logic                rr_adv;

    for (genvar i = 0; i < WAYS; i++) begin : g_way
        assign empty[i] = bus.in_states[i*STATE_BITS +: STATE_BITS] == STATE_BITS'(INVALID_STATE);
        assign match[i] = !empty[i] && bus.in_tags[i*TAG_BITS +: TAG_BITS] == bus.in_tag;
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit_way = '0;
        empty_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) hit_way = WAY_BITS'(i);
            if (empty[i]) empty_way = WAY_BITS'(i);
        end
    end

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi = |(match & (match - 1'b1));
    assign any_hit = |match;
    assign any_empty = |empty;
    assign is_evict = bus.in_mode == 2'd2;
    assign is_fwd = bus.in_mode[0];
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign rr_adv = accept && !is_fwd && !any_empty && (is_evict || !any_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_mode <= '0;
            bus.out_tag_hit <= 1'b0;
            bus.out_way_hit <= '0;
            bus.out_empty_found <= 1'b0;
            bus.out_empty_way <= '0;
            bus.out_evict_way <= '0;
            bus.out_multi_hit <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_mode <= bus.in_mode;
                bus.out_tag_hit <= any_hit && !is_evict;
                bus.out_way_hit <= is_evict ? '0 : hit_way;
                bus.out_multi_hit <= multi && !is_evict;
                bus.out_empty_found <= any_empty && !is_fwd;
                bus.out_empty_way <= is_fwd ? '0 : empty_way;
                bus.out_evict_way <= is_fwd ? '0 : any_empty ? empty_way : rr_ptr;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (rr_adv) rr_ptr <= rr_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_l2_lookup_pipe.sv
// tb_l2_lookup_pipe: directed vectors with hand-computed results for l2_lookup_pipe
module tb_l2_lookup_pipe;
    localparam int WAYS = 8;
    localparam int TB = 20;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    logic [TB-1:0] tags [WAYS];
    logic [SB-1:0] sts [WAYS];

    l2_lookup_pipe_if #(.WAYS(WAYS), .TAG_BITS(TB), .STATE_BITS(SB)) bus ();

    l2_lookup_pipe #(.WAYS(WAYS), .TAG_BITS(TB), .STATE_BITS(SB), .INVALID_STATE(0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.in_tags = '0;
        bus.in_states = '0;
        for (int i = 0; i < WAYS; i++) begin
            bus.in_tags[i*TB +: TB] = tags[i];
            bus.in_states[i*SB +: SB] = sts[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic full_set();
        for (int i = 0; i < WAYS; i++) begin
            tags[i] = TB'(32'h100 + i);
            sts[i] = 3'd1;
        end
    endtask

    task automatic req(input logic [1:0] mode, input logic [TB-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_mode = mode;
        bus.in_tag = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string nm, input logic [1:0] mode, input logic hit, input logic [2:0] hw,
                           input logic ef, input logic [2:0] ew, input logic [2:0] ev, input logic mh);
        check({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, ".mode"}, 32'(bus.out_mode), 32'(mode));
        check({nm, ".tag_hit"}, 32'(bus.out_tag_hit), 32'(hit));
        check({nm, ".way_hit"}, 32'(bus.out_way_hit), 32'(hw));
        check({nm, ".empty_found"}, 32'(bus.out_empty_found), 32'(ef));
        check({nm, ".empty_way"}, 32'(bus.out_empty_way), 32'(ew));
        check({nm, ".evict_way"}, 32'(bus.out_evict_way), 32'(ev));
        check({nm, ".multi_hit"}, 32'(bus.out_multi_hit), 32'(mh));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_mode = 2'd0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        full_set();
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.evict_way", 32'(bus.out_evict_way), 32'd0);
        check("rst.out_mode", 32'(bus.out_mode), 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);

        // hit in way 5, way 2 empty -> victim is the empty way
        tags[5] = 20'h00123;
        sts[2] = 3'd0;
        req(2'd0, 20'h00123);
        step();
        chk_res("hit5", 2'd0, 1'b1, 3'd5, 1'b1, 3'd2, 3'd2, 1'b0);

        // nine full-set misses: victims 0..7 then wrap to 0
        full_set();
        req(2'd0, 20'hFFFFF);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("rr%0d.valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("rr%0d.evict", k), 32'(bus.out_evict_way), 32'(k % 8));
            check($sformatf("rr%0d.in_ready", k), 32'(bus.in_ready), 32'd1);
        end
        // rr_ptr = 1

        // forward lookups: only hit fields are meaningful
        sts[0] = 3'd0;
        tags[3] = 20'h00ABC;
        req(2'd1, 20'h00ABC);
        step();
        chk_res("fwd", 2'd1, 1'b1, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);
        req(2'd3, 20'h00ABC);
        step();
        chk_res("mode3", 2'd3, 1'b1, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);

        // back-pressure: A loaded, B held off for three cycles
        full_set();
        req(2'd0, 20'hFFFFF);
        step();
        chk_res("bpA", 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd1, 1'b0);
        bus.out_ready = 1'b0;
        req(2'd2, 20'hFFFFF);
        #1;
        check("bp.in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bp%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
            chk_res($sformatf("bp%0d", k), 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd1, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        chk_res("bpB", 2'd2, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2, 1'b0);
        // rr_ptr = 3

        // every way holds the same valid tag
        for (int i = 0; i < WAYS; i++) tags[i] = 20'h77777;
        req(2'd0, 20'h77777);
        step();
        chk_res("alleq", 2'd0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd3, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // duplicate tag in ways 1 and 6
        full_set();
        tags[1] = 20'h5A5A5;
        tags[6] = 20'h5A5A5;
        req(2'd0, 20'h5A5A5);
        step();
        chk_res("multi", 2'd0, 1'b1, 3'd1, 1'b0, 3'd0, 3'd3, 1'b1);
        req(2'd2, 20'h5A5A5);
        step();
        chk_res("evict", 2'd2, 1'b0, 3'd0, 1'b0, 3'd0, 3'd3, 1'b0);
        // rr_ptr = 4, out_valid = 1

        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.evict_way", 32'(bus.out_evict_way), 32'd0);
        step();
        rst = 1'b0;
        full_set();
        req(2'd0, 20'hFFFFF);
        step();
        chk_res("postrst", 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        bus.in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
